// File: rtl/aes128_inv_key_sched.sv
// AES-128 round-key generator for decryption: emits round keys 10 down to 0, one per handshake.
// Starting from the cipher key, the schedule is first rolled forward to round 10.
module aes128_inv_key_sched #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         key_is_last,
    input  logic [0:127] key,
    input  logic         abort,
    output logic         start_ready,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_data,
    output logic [3:0]   rk_round,
    output logic         done
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [3:0] LastRound = 4'(NR);

    typedef enum logic [1:0] {StIdle, StFwd, StOut} state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_e       state_q;
    logic [0:127] key_q;

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  p1, p2, p3;
    logic [31:0]  sub_in, rot, sub_out, rcon_w, t0, n1, n2, n3;
    logic [3:0]   rcon_idx;
    logic [0:127] fwd_key, bwd_key;

    // One SubWord path shared by both directions: forward uses k3, backward uses recovered p3.
    always_comb begin
        k0 = key_q[0:31];
        k1 = key_q[32:63];
        k2 = key_q[64:95];
        k3 = key_q[96:127];
        p3 = k3 ^ k2;
        p2 = k2 ^ k1;
        p1 = k1 ^ k0;
        if (state_q == StFwd) begin
            sub_in   = k3;
            rcon_idx = rk_round + 4'd1;
        end else begin
            sub_in   = p3;
            rcon_idx = rk_round;
        end
        rot     = {sub_in[23:0], sub_in[31:24]};
        sub_out = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        rcon_w  = {rcon(rcon_idx), 24'h000000};
        t0      = k0 ^ sub_out ^ rcon_w;
        n1      = k1 ^ t0;
        n2      = k2 ^ n1;
        n3      = k3 ^ n2;
        fwd_key = {t0, n1, n2, n3};
        bwd_key = {t0, p1, p2, p3};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            key_q    <= '0;
            rk_round <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    // start is not honoured in the done cycle
                    if (start && !done) begin
                        key_q <= key;
                        if (key_is_last) begin
                            state_q  <= StOut;
                            rk_round <= LastRound;
                        end else begin
                            state_q  <= StFwd;
                            rk_round <= 4'd0;
                        end
                    end
                end
                StFwd: begin
                    if (abort) begin
                        state_q  <= StIdle;
                        key_q    <= '0;
                        rk_round <= 4'd0;
                    end else begin
                        key_q    <= fwd_key;
                        rk_round <= rk_round + 4'd1;
                        if (rk_round == LastRound - 4'd1) begin
                            state_q <= StOut;
                        end
                    end
                end
                StOut: begin
                    if (abort) begin
                        state_q  <= StIdle;
                        key_q    <= '0;
                        rk_round <= 4'd0;
                    end else if (rk_ready) begin
                        if (rk_round == 4'd0) begin
                            state_q <= StIdle;
                            done    <= 1'b1;
                        end else begin
                            key_q    <= bwd_key;
                            rk_round <= rk_round - 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rk_data     = key_q;
    assign rk_valid    = (state_q == StOut);
    assign busy        = (state_q != StIdle);
    assign start_ready = (state_q == StIdle) && !done;

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// Directed bench for aes128_inv_key_sched using FIPS-197 A.1 and C.1 key schedules.
module tb_aes128_inv_key_sched;

    logic         clk = 1'b0;
    logic         rst_n, start, key_is_last, abort, rk_ready;
    logic [0:127] key, rk_data;
    logic         start_ready, busy, rk_valid, done;
    logic [3:0]   rk_round;

    int checks   = 0;
    int failures = 0;

    logic [127:0] a1 [0:10];
    logic [127:0] c1_last, c1_first, held_d;
    logic [3:0]   held_r;
    int           acc;
    bit           stalled, seen_done;

    always #5 clk = ~clk;

    aes128_inv_key_sched #(.NR(10)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .key_is_last (key_is_last),
        .key         (key),
        .abort       (abort),
        .start_ready (start_ready),
        .busy        (busy),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_data     (rk_data),
        .rk_round    (rk_round),
        .done        (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Presents rounds 10..0 with rk_ready=1 and checks each key, then the done pulse.
    task automatic drain_a1(input string tag, input bit busy_chk);
        for (int r = 10; r >= 0; r--) begin
            chkn({tag, "_valid"}, 32'(rk_valid), 32'd1);
            chkn({tag, "_round"}, 32'(rk_round), 32'(r));
            chk({tag, "_data"}, rk_data, a1[r]);
            if (busy_chk) begin
                chkn({tag, "_start_ready"}, 32'(start_ready), 32'd0);
                chkn({tag, "_busy"}, 32'(busy), 32'd1);
            end
            tick;
        end
        chkn({tag, "_done"}, 32'(done), 32'd1);
        chkn({tag, "_valid_after"}, 32'(rk_valid), 32'd0);
        chkn({tag, "_start_ready_done"}, 32'(start_ready), 32'd0);
    endtask

    initial begin
        a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        c1_last  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        c1_first = 128'h000102030405060708090a0b0c0d0e0f;

        rst_n = 1'b0; start = 1'b0; key_is_last = 1'b0; abort = 1'b0; rk_ready = 1'b0;
        key = '0;
        tick; tick;
        rst_n = 1'b1;
        chkn("rst_start_ready", 32'(start_ready), 32'd1);
        chkn("rst_busy", 32'(busy), 32'd0);
        chkn("rst_valid", 32'(rk_valid), 32'd0);
        chkn("rst_done", 32'(done), 32'd0);
        chkn("rst_round", 32'(rk_round), 32'd0);
        chk("rst_data", rk_data, 128'h0);

        // A.1 from the cipher key, rk_ready held high
        rk_ready = 1'b1;
        key = a1[0]; key_is_last = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        chkn("a1_busy", 32'(busy), 32'd1);
        chkn("a1_start_ready", 32'(start_ready), 32'd0);
        repeat (10) begin
            chkn("a1_fwd_valid", 32'(rk_valid), 32'd0);
            tick;
        end
        drain_a1("a1", 1'b0);
        tick;
        chkn("a1_done_pulse", 32'(done), 32'd0);
        chkn("a1_idle_ready", 32'(start_ready), 32'd1);

        // C.1 starting from the last round key
        key = c1_last; key_is_last = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        chkn("c1_valid", 32'(rk_valid), 32'd1);
        chkn("c1_round10", 32'(rk_round), 32'd10);
        chk("c1_data10", rk_data, c1_last);
        repeat (10) tick;
        chkn("c1_round0", 32'(rk_round), 32'd0);
        chk("c1_data0", rk_data, c1_first);
        tick;
        chkn("c1_done", 32'(done), 32'd1);
        tick;

        // A.1 with random backpressure
        key = a1[0]; key_is_last = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        acc = 0; stalled = 1'b0; seen_done = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            if (stalled) begin
                chk("bp_hold_data", rk_data, held_d);
                chkn("bp_hold_round", 32'(rk_round), 32'(held_r));
            end
            if (done) begin
                seen_done = 1'b1;
            end else if (rk_valid) begin
                rk_ready = 1'($urandom_range(0, 1));
                if (rk_ready) begin
                    if (acc < 11) begin
                        chk("bp_data", rk_data, a1[10 - acc]);
                        chkn("bp_round", 32'(rk_round), 32'(10 - acc));
                    end else begin
                        chkn("bp_extra_accept", 32'(acc), 32'd10);
                    end
                    acc++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = rk_data;
                    held_r  = rk_round;
                end
            end
            if (!seen_done) tick;
        end
        chkn("bp_accepts", 32'(acc), 32'd11);
        chkn("bp_done_seen", 32'(seen_done), 32'd1);
        rk_ready = 1'b1;
        tick;

        // abort part-way through the forward walk
        key = a1[0]; key_is_last = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (4) tick;
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chkn("abf_start_ready", 32'(start_ready), 32'd1);
        chkn("abf_busy", 32'(busy), 32'd0);
        chkn("abf_valid", 32'(rk_valid), 32'd0);
        chkn("abf_done", 32'(done), 32'd0);
        chk("abf_key_cleared", rk_data, 128'h0);
        key = c1_last; key_is_last = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        chkn("abf_restart_valid", 32'(rk_valid), 32'd1);
        chk("abf_restart_data", rk_data, c1_last);

        // abort concurrent with a handshake at round 6
        repeat (4) tick;
        chkn("abo_round6", 32'(rk_round), 32'd6);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chkn("abo_valid", 32'(rk_valid), 32'd0);
        chkn("abo_done", 32'(done), 32'd0);
        chkn("abo_start_ready", 32'(start_ready), 32'd1);
        chk("abo_key_cleared", rk_data, 128'h0);
        tick;
        chkn("abo_no_late_done", 32'(done), 32'd0);

        // start held high with another key for the whole A.1 run
        key = a1[0]; key_is_last = 1'b0; start = 1'b1;
        tick;
        key = c1_last; key_is_last = 1'b1;
        repeat (10) begin
            chkn("sb_fwd_valid", 32'(rk_valid), 32'd0);
            chkn("sb_fwd_busy", 32'(busy), 32'd1);
            chkn("sb_fwd_start_ready", 32'(start_ready), 32'd0);
            tick;
        end
        drain_a1("sb", 1'b1);
        // start still high in the done cycle must be ignored
        tick;
        start = 1'b0;
        chkn("sb_done_start_ignored", 32'(busy), 32'd0);
        chkn("sb_idle_ready", 32'(start_ready), 32'd1);

        // synchronous reset in OUT at round 4
        key = a1[0]; key_is_last = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        repeat (6) tick;
        chkn("rs_round4", 32'(rk_round), 32'd4);
        chk("rs_data4", rk_data, a1[4]);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        chkn("rs_valid", 32'(rk_valid), 32'd0);
        chkn("rs_round", 32'(rk_round), 32'd0);
        chkn("rs_start_ready", 32'(start_ready), 32'd1);
        chkn("rs_done", 32'(done), 32'd0);
        chk("rs_data", rk_data, 128'h0);
        key = a1[0]; key_is_last = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (10) tick;
        drain_a1("rs_rerun", 1'b0);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
